// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer: FSM state encoding,
// instruction stride and reset/trap fetch addresses.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_e;

  localparam logic [31:0] INSTR_BYTES  = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pc_seq_stats.sv
// Performance counters for redirects and stall cycles.
// Latency: count visible one cycle after the event. Never backpressures; both counters wrap at 2^32.
module pc_seq_stats (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_i,
  input  logic        stall_event_i,
  output logic [31:0] redirect_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (redirect_i)    redirect_cnt_d = redirect_cnt_q + 32'd1;
    if (stall_event_i) stall_cnt_d    = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with BOOT/RUN/TRAP FSM; redirect to target, trap on misaligned target.
// Latency: 1-cycle redirect; stall_i / !imem_ready_i hold the PC. Counters only with PC_SEQ_STATS_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_PC  = TRAP_PC_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        imem_ready_i,
  input  logic        ex_valid_i,
  input  logic        ex_pc_src_i,
  input  logic [31:0] ex_target_i,
  input  logic        trap_ack_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        flush_o,
  output logic        misalign_o,
  output logic [31:0] redirect_cnt_o,
  output logic [31:0] stall_cnt_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect;
  logic        misalign;

  assign redirect = (state_q == RUN) && ex_valid_i && ex_pc_src_i;
  assign misalign = redirect && (ex_target_i[1:0] != 2'b00);

  // Priority inside RUN: redirect > stall > imem not ready > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (misalign) begin
          pc_d    = TRAP_PC;
          state_d = TRAP;
        end else if (redirect) begin
          pc_d = ex_target_i;
        end else if (!stall_i && imem_ready_i) begin
          pc_d = pc_q + INSTR_BYTES;
        end
      end
      TRAP: if (trap_ack_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = (state_q == RUN);
  assign flush_o       = redirect;
  assign misalign_o    = misalign;

`ifdef PC_SEQ_STATS_EN
  logic stall_event;
  assign stall_event = (state_q == RUN) && stall_i && !redirect;

  pc_seq_stats u_stats (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_i     (redirect),
    .stall_event_i  (stall_event),
    .redirect_cnt_o (redirect_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
  );
`else
  assign redirect_cnt_o = 32'd0;
  assign stall_cnt_o    = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequencing, redirects, trap, wrap, async reset.
module tb_pc_sequencer;

`ifdef PC_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, imem_ready_i, ex_valid_i, ex_pc_src_i, trap_ack_i;
  logic [31:0] ex_target_i;
  logic [31:0] pc_o, redirect_cnt_o, stall_cnt_o;
  logic        fetch_valid_o, flush_o, misalign_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall_i        (stall_i),
    .imem_ready_i   (imem_ready_i),
    .ex_valid_i     (ex_valid_i),
    .ex_pc_src_i    (ex_pc_src_i),
    .ex_target_i    (ex_target_i),
    .trap_ack_i     (trap_ack_i),
    .pc_o           (pc_o),
    .fetch_valid_o  (fetch_valid_o),
    .flush_o        (flush_o),
    .misalign_o     (misalign_o),
    .redirect_cnt_o (redirect_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input logic [31:0] n);
    return STATS ? n : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] tgt);
    ex_valid_i  = v;
    ex_pc_src_i = v;
    ex_target_i = tgt;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b1;
    ex_valid_i = 1'b0; ex_pc_src_i = 1'b0; ex_target_i = 32'h0; trap_ack_i = 1'b0;
    #2;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_fv", {31'd0, fetch_valid_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    chk("rst_rcnt", redirect_cnt_o, 32'd0);
    chk("rst_scnt", stall_cnt_o, 32'd0);

    #10 reset_n = 1'b1;
    #1;
    chk("boot_fv", {31'd0, fetch_valid_o}, 32'd0);
    chk("boot_pc", pc_o, 32'h0);
    tick();
    chk("run_fv", {31'd0, fetch_valid_o}, 32'd1);
    chk("run_pc0", pc_o, 32'h0);
    tick(); chk("run_pc4", pc_o, 32'h4);
    tick(); chk("run_pc8", pc_o, 32'h8);
    tick(); tick(); chk("run_pc10", pc_o, 32'h10);

    // aligned redirect
    set_ex(1'b1, 32'h40);
    chk("redir_flush", {31'd0, flush_o}, 32'd1);
    chk("redir_mis", {31'd0, misalign_o}, 32'd0);
    tick(); set_ex(1'b0, 32'h0);
    chk("redir_pc", pc_o, 32'h40);
    chk("redir_flush_off", {31'd0, flush_o}, 32'd0);
    chk("redir_cnt1", redirect_cnt_o, cnt(32'd1));

    // stall, then redirect with stall
    stall_i = 1'b1;
    tick();
    chk("stall_hold", pc_o, 32'h40);
    chk("stall_cnt1", stall_cnt_o, cnt(32'd1));
    set_ex(1'b1, 32'h80);
    chk("rs_flush", {31'd0, flush_o}, 32'd1);
    tick(); set_ex(1'b0, 32'h0); stall_i = 1'b0;
    chk("rs_pc", pc_o, 32'h80);
    chk("rs_scnt", stall_cnt_o, cnt(32'd1));
    chk("rs_rcnt", redirect_cnt_o, cnt(32'd2));

    // imem not ready holds
    imem_ready_i = 1'b0;
    tick();
    chk("nrdy_hold", pc_o, 32'h80);
    chk("nrdy_scnt", stall_cnt_o, cnt(32'd1));
    imem_ready_i = 1'b1;

    // misaligned redirect -> TRAP
    set_ex(1'b1, 32'h42);
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_flush", {31'd0, flush_o}, 32'd1);
    tick();
    set_ex(1'b1, 32'h200);
    chk("trap_pc", pc_o, 32'h100);
    chk("trap_fv", {31'd0, fetch_valid_o}, 32'd0);
    chk("trap_mis", {31'd0, misalign_o}, 32'd0);
    chk("trap_noflush", {31'd0, flush_o}, 32'd0);
    chk("trap_rcnt", redirect_cnt_o, cnt(32'd3));
    tick();
    chk("trap_hold", pc_o, 32'h100);
    chk("trap_fv2", {31'd0, fetch_valid_o}, 32'd0);
    set_ex(1'b0, 32'h0);
    trap_ack_i = 1'b1;
    tick(); trap_ack_i = 1'b0;
    chk("ack_fv", {31'd0, fetch_valid_o}, 32'd1);
    chk("ack_pc", pc_o, 32'h100);
    tick(); chk("ack_pc104", pc_o, 32'h104);

    // wrap
    set_ex(1'b1, 32'hFFFF_FFF8);
    tick(); set_ex(1'b0, 32'h0);
    chk("wrap_pcf8", pc_o, 32'hFFFF_FFF8);
    tick(); chk("wrap_pcfc", pc_o, 32'hFFFF_FFFC);
    tick(); chk("wrap_pc0", pc_o, 32'h0);
    chk("wrap_rcnt", redirect_cnt_o, cnt(32'd4));
    tick(); chk("wrap_pc4", pc_o, 32'h4);

    // async reset mid-stall
    stall_i = 1'b1;
    tick();
    chk("pre_rst_hold", pc_o, 32'h4);
    chk("pre_rst_scnt", stall_cnt_o, cnt(32'd2));
    #1 reset_n = 1'b0;
    #1;
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_fv", {31'd0, fetch_valid_o}, 32'd0);
    chk("arst_rcnt", redirect_cnt_o, 32'd0);
    chk("arst_scnt", stall_cnt_o, 32'd0);
    stall_i = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    chk("rel_fv", {31'd0, fetch_valid_o}, 32'd1);
    chk("rel_pc", pc_o, 32'h0);
    tick(); chk("rel_pc4", pc_o, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter TRAP_PC, default 32'h0000_0100, meaning fetch address after a misaligned redirect.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall_i  input  1  hazard-unit stall; hold PC.
REQ-006 SHALL have port imem_ready_i  input  1  instruction memory accepts fetch at pc_o.
REQ-007 SHALL have port ex_valid_i  input  1  EX stage holds a valid instruction.
REQ-008 SHALL have port ex_pc_src_i  input  1  PcSrc from branch control (taken branch or jump).
REQ-009 SHALL have port ex_target_i  input  32  ALU-computed redirect target.
REQ-010 SHALL have port trap_ack_i  input  1  trap handler ready; leave TRAP state.
REQ-011 SHALL have port pc_o  output  32  current fetch PC (registered).
REQ-012 SHALL have port fetch_valid_o  output  1  pc_o is a valid fetch request.
REQ-013 SHALL have port flush_o  output  1  kill IF/ID and ID/EX contents this cycle.
REQ-014 SHALL have port misalign_o  output  1  one-cycle pulse, redirect target with ex_target_i[1:0] != 0.
REQ-015 SHALL have ports redirect_cnt_o, stall_cnt_o  output  32 each  performance counters.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, TRAP; BOOT -> RUN unconditionally after one cycle; RUN -> TRAP on misaligned redirect; TRAP -> RUN when trap_ack_i = 1.
REQ-017 SHALL drive fetch_valid_o = 1 only in RUN.
REQ-018 SHALL define redirect = RUN & ex_valid_i & ex_pc_src_i, evaluated combinationally.
REQ-019 SHALL assert flush_o combinationally in the same cycle as redirect, aligned or misaligned.
REQ-020 SHALL, on aligned redirect, load pc_o <= ex_target_i at the next edge (1-cycle redirect latency).
REQ-021 SHALL, on misaligned redirect, load pc_o <= TRAP_PC, pulse misalign_o for that cycle, and enter TRAP.
REQ-022 SHALL, in RUN without redirect, advance pc_o by 4 only when imem_ready_i = 1 and stall_i = 0; otherwise hold.
REQ-023 SHALL give priority redirect > stall > imem_ready_i = 0 > increment.
REQ-024 SHALL wrap pc_o from 32'hFFFF_FFFC to 32'h0000_0000 (modulo 2^32).
REQ-025 SHALL ignore ex_valid_i/ex_pc_src_i in BOOT and TRAP (no flush_o, no pc_o change).
REQ-026 SHALL hold pc_o in TRAP; on the trap_ack_i cycle pc_o remains TRAP_PC and fetch resumes there in RUN.

Reset
REQ-027 SHALL, on reset_n low at any time, immediately set pc_o = RESET_PC, state = BOOT, fetch_valid_o = 0, flush_o = 0, misalign_o = 0, both counters = 0.
REQ-028 SHALL leave BOOT on the first rising edge after reset_n deasserts.

Configuration
REQ-029 SHALL compile performance counters only when PC_SEQ_STATS_EN is defined.
REQ-030 SHALL, with PC_SEQ_STATS_EN, increment redirect_cnt_o once per redirect cycle and stall_cnt_o once per RUN cycle with stall_i = 1 and no redirect; both wrap at 2^32.
REQ-031 SHALL, without PC_SEQ_STATS_EN, keep the ports and tie both counters to 0.

Structure
REQ-032 SHALL place the state enum (BOOT, RUN, TRAP), INSTR_BYTES = 4, and RESET_PC/TRAP_PC defaults in package pc_seq_pkg.
REQ-033 SHALL implement counters in sub-module pc_seq_stats, instantiated only under PC_SEQ_STATS_EN.

Verification
REQ-034 SHALL test reset release: pc_o = 0, fetch_valid_o = 0 one cycle, then 0x0, 0x4, 0x8 with imem_ready_i = 1.
REQ-035 SHALL test aligned redirect at pc_o = 0x10 with target 0x40: flush_o = 1 that cycle, next pc_o = 0x40, redirect_cnt_o = 1.
REQ-036 SHALL test redirect with stall_i = 1 simultaneously: redirect wins, pc_o = target, stall_cnt_o unchanged.
REQ-037 SHALL test target 0x42: misalign_o pulse, pc_o = 0x100, fetch_valid_o = 0 until trap_ack_i, then fetch from 0x100.
REQ-038 SHALL test wrap and mid-run reset: pc_o 0xFFFF_FFFC -> 0x0; reset_n low mid-stall forces pc_o = RESET_PC asynchronously.
